// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - four-line interrupt edge latch, mask, arbitration and vector/ack handshake
//
// Purpose: latches rising edges of irq_in as pending bits, masks them with the
// IO-writable enable register, picks one winner and presents it to the CPU as
// int_req plus int_vector. A CPU acknowledge retires the winner, which clears its
// pending bit and sends a one-cycle clear pulse back to the peripheral.
//
// Configuration macro: IRQ_ROTATE_PRIORITY_EN
//   defined   -> rotating priority; the search starts at a 2-bit pointer that moves
//                to the bit after the one just acknowledged
//   undefined -> fixed priority, bit 0 highest
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   irq_in[3:0]            peripheral interrupt levels (bit 0 = interrupt_0)
//   cpu_ie                 CPU global interrupt enable
//   int_req, int_vector    request and 16-bit vector to the CPU control unit
//   int_ack                one-cycle accept pulse from the control unit
//   irq_clr[3:0]           one-hot, one-cycle clear pulse to the retired peripheral
//   io_addr, io_wr_en, io_rd_en, io_din, io_dout
//                          IO register port (enable at EN_ADDR, pending at PEND_ADDR)

module irq_arbiter #(
  parameter logic [15:0] VECTOR_BASE   = 16'h0008,
  parameter logic [15:0] VECTOR_STRIDE = 16'd4,
  parameter logic [7:0]  EN_ADDR       = 8'h00,
  parameter logic [7:0]  PEND_ADDR     = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  irq_in,
  input  logic        cpu_ie,
  output logic        int_req,
  input  logic        int_ack,
  output logic [15:0] int_vector,
  output logic [3:0]  irq_clr,
  input  logic [7:0]  io_addr,
  input  logic        io_wr_en,
  input  logic        io_rd_en,
  input  logic [7:0]  io_din,
  output logic [7:0]  io_dout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  enable;
  logic [3:0]  pending;
  logic [3:0]  irq_d;
  logic [1:0]  id;
  logic [3:0]  eligible;
  logic [1:0]  winner;
  logic        load_id;
  logic        retire;
  logic [3:0]  pend_set;
  logic [3:0]  pend_clr;
  logic        unused_din;

  // Only the low nibble of write data is architected.
  assign unused_din = ^io_din[7:4];

  assign eligible = pending & enable;
  assign pend_set = irq_in & ~irq_d;

  // Vector follows the latched id, so it is stable for the whole REQ phase.
  assign int_vector = VECTOR_BASE + 16'(id) * VECTOR_STRIDE;

`ifdef IRQ_ROTATE_PRIORITY_EN
  logic [1:0] ptr;
  logic [1:0] cand;

  // Search from the highest offset down so the lowest offset above ptr wins.
  always_comb begin
    winner = 2'd0;
    cand   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (eligible[cand]) begin
        winner = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 2'd0;
    end else if (retire) begin
      ptr <= id + 2'd1;
    end
  end
`else
  always_comb begin
    winner = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (eligible[k]) begin
        winner = 2'(k);
      end
    end
  end
`endif

  always_comb begin
    state_next = state;
    int_req    = 1'b0;
    retire     = 1'b0;
    load_id    = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_ie && (|eligible)) begin
          load_id    = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        int_req = 1'b1;
        if (int_ack) begin
          retire     = 1'b1;
          state_next = DONE;
        end else if (!cpu_ie || !eligible[id]) begin
          // Request withdrawn (masked, cleared or globally disabled); no clear pulse.
          state_next = IDLE;
        end
      end
      DONE: begin
        // One quiet cycle lets the CPU's own IE clear take effect before re-arbitration.
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Clear sources: the retired id and any W1C write. A same-cycle set overrides both.
  always_comb begin
    pend_clr = 4'd0;
    if (retire) begin
      pend_clr = pend_clr | (4'b0001 << id);
    end
    if (io_wr_en && (io_addr == PEND_ADDR)) begin
      pend_clr = pend_clr | io_din[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      enable  <= 4'd0;
      pending <= 4'd0;
      irq_d   <= 4'd0;
      id      <= 2'd0;
      irq_clr <= 4'd0;
      io_dout <= 8'd0;
    end else begin
      state   <= state_next;
      irq_d   <= irq_in;
      pending <= (pending & ~pend_clr) | pend_set;
      irq_clr <= retire ? (4'b0001 << id) : 4'd0;
      if (load_id) begin
        id <= winner;
      end
      if (io_wr_en && (io_addr == EN_ADDR)) begin
        enable <= io_din[3:0];
      end
      if (io_rd_en) begin
        if (io_addr == EN_ADDR) begin
          io_dout <= {4'd0, enable};
        end else if (io_addr == PEND_ADDR) begin
          io_dout <= {4'd0, pending};
        end else begin
          io_dout <= 8'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// tb/tb_irq_arbiter.sv - self-checking bench for irq_arbiter with an expected-grant scoreboard
module tb_irq_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  irq_in;
  logic        cpu_ie;
  logic        int_req;
  logic        int_ack;
  logic [15:0] int_vector;
  logic [3:0]  irq_clr;
  logic [7:0]  io_addr;
  logic        io_wr_en;
  logic        io_rd_en;
  logic [7:0]  io_din;
  logic [7:0]  io_dout;

  typedef struct packed {
    logic [15:0] vec;
    logic [3:0]  clr;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] rd;
  bit   seen;

  irq_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .cpu_ie     (cpu_ie),
    .int_req    (int_req),
    .int_ack    (int_ack),
    .int_vector (int_vector),
    .irq_clr    (irq_clr),
    .io_addr    (io_addr),
    .io_wr_en   (io_wr_en),
    .io_rd_en   (io_rd_en),
    .io_din     (io_din),
    .io_dout    (io_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    io_addr  = a;
    io_din   = d;
    io_wr_en = 1'b1;
    tick();
    io_wr_en = 1'b0;
  endtask

  task automatic io_read(input logic [7:0] a, output logic [7:0] d);
    io_addr  = a;
    io_rd_en = 1'b1;
    tick();
    io_rd_en = 1'b0;
    d = io_dout;
  endtask

  task automatic wait_req(input int max_cycles, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (int_req === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL reset_int_req got=%b exp=0", int_req); end
    checks++; if (int_vector !== 16'h0008) begin errors++; $display("FAIL reset_vector got=%h exp=0008", int_vector); end
    checks++; if (irq_clr !== 4'b0000) begin errors++; $display("FAIL reset_irq_clr got=%b exp=0000", irq_clr); end
    checks++; if (io_dout !== 8'h00) begin errors++; $display("FAIL reset_io_dout got=%h exp=00", io_dout); end
    reset = 1'b0;
    tick();
    io_read(8'h00, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL reset_enable got=%h exp=00", rd); end
    io_read(8'h01, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL reset_pending got=%h exp=00", rd); end
  endtask

  task automatic test_retire();
    io_write(8'h00, 8'h0F);
    cpu_ie = 1'b1;
    exp_q.push_back('{vec: 16'h0010, clr: 4'b0100});
    irq_in = 4'b0100;
    tick();
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL retire_latency1 got=%b exp=0", int_req); end
    tick();
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL retire_latency2 got=%b exp=1", int_req); end
    irq_in = 4'b0000;
    e = exp_q.pop_front();
    checks++; if (int_vector !== e.vec) begin errors++; $display("FAIL retire_vector got=%h exp=%h", int_vector, e.vec); end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    checks++; if (irq_clr !== e.clr) begin errors++; $display("FAIL retire_clr got=%b exp=%b", irq_clr, e.clr); end
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL retire_done_req got=%b exp=0", int_req); end
    tick();
    checks++; if (irq_clr !== 4'b0000) begin errors++; $display("FAIL retire_clr_width got=%b exp=0000", irq_clr); end
    io_read(8'h01, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL retire_pending got=%h exp=00", rd); end
  endtask

  task automatic test_simultaneous();
    exp_q.push_back('{vec: 16'h000C, clr: 4'b0010});
    exp_q.push_back('{vec: 16'h0014, clr: 4'b1000});
    irq_in = 4'b1010;
    tick();
    irq_in = 4'b0000;
    for (int n = 0; n < 2; n++) begin
      wait_req(10, seen);
      checks++; if (!seen) begin errors++; $display("FAIL simul_req_timeout grant=%0d got=0 exp=1", n); end
      e = exp_q.pop_front();
      checks++; if (int_vector !== e.vec) begin errors++; $display("FAIL simul_vector grant=%0d got=%h exp=%h", n, int_vector, e.vec); end
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      checks++; if (irq_clr !== e.clr) begin errors++; $display("FAIL simul_clr grant=%0d got=%b exp=%b", n, irq_clr, e.clr); end
    end
    tick();
  endtask

  task automatic test_masking();
    io_write(8'h00, 8'h00);
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    tick();
    tick();
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL mask_no_req got=%b exp=0", int_req); end
    io_read(8'h01, rd);
    checks++; if (rd !== 8'h01) begin errors++; $display("FAIL mask_pending got=%h exp=01", rd); end
    exp_q.push_back('{vec: 16'h0008, clr: 4'b0001});
    io_write(8'h00, 8'h01);
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL mask_enable_edge got=%b exp=0", int_req); end
    tick();
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL mask_unmask_req got=%b exp=1", int_req); end
    e = exp_q.pop_front();
    checks++; if (int_vector !== e.vec) begin errors++; $display("FAIL mask_vector got=%h exp=%h", int_vector, e.vec); end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    checks++; if (irq_clr !== e.clr) begin errors++; $display("FAIL mask_clr got=%b exp=%b", irq_clr, e.clr); end
    tick();
    io_write(8'h00, 8'h0F);
  endtask

  task automatic test_withdraw();
    exp_q.push_back('{vec: 16'h0008, clr: 4'b0000});
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    wait_req(10, seen);
    checks++; if (!seen) begin errors++; $display("FAIL withdraw_req_timeout got=0 exp=1"); end
    e = exp_q.pop_front();
    checks++; if (int_vector !== e.vec) begin errors++; $display("FAIL withdraw_vector got=%h exp=%h", int_vector, e.vec); end
    cpu_ie = 1'b0;
    tick();
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL withdraw_req got=%b exp=0", int_req); end
    checks++; if (irq_clr !== e.clr) begin errors++; $display("FAIL withdraw_clr got=%b exp=%b", irq_clr, e.clr); end
    tick();
    checks++; if (irq_clr !== 4'b0000) begin errors++; $display("FAIL withdraw_clr_late got=%b exp=0000", irq_clr); end
    io_read(8'h01, rd);
    checks++; if (rd !== 8'h01) begin errors++; $display("FAIL withdraw_pending got=%h exp=01", rd); end
    io_write(8'h01, 8'h01);
    cpu_ie = 1'b1;
    tick();
    tick();
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL withdraw_w1c_clean got=%b exp=0", int_req); end
  endtask

  task automatic test_w1c_race();
    io_write(8'h00, 8'h00);
    irq_in   = 4'b0010;
    io_addr  = 8'h01;
    io_din   = 8'h02;
    io_wr_en = 1'b1;
    tick();
    io_wr_en = 1'b0;
    irq_in   = 4'b0000;
    io_read(8'h01, rd);
    checks++; if (rd !== 8'h02) begin errors++; $display("FAIL w1c_race_set_wins got=%h exp=02", rd); end
    io_write(8'h01, 8'h02);
    io_read(8'h01, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL w1c_clear got=%h exp=00", rd); end
    io_read(8'h00, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL en_readback got=%h exp=00", rd); end
    io_read(8'h07, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL bad_addr_read got=%h exp=00", rd); end
    io_write(8'h00, 8'h0F);
    io_read(8'h00, rd);
    checks++; if (rd !== 8'h0F) begin errors++; $display("FAIL en_readback_f got=%h exp=0F", rd); end
  endtask

  task automatic test_level_hold();
    exp_q.push_back('{vec: 16'h0010, clr: 4'b0100});
    irq_in = 4'b0100;
    wait_req(10, seen);
    checks++; if (!seen) begin errors++; $display("FAIL level_req_timeout got=0 exp=1"); end
    e = exp_q.pop_front();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    checks++; if (irq_clr !== e.clr) begin errors++; $display("FAIL level_clr got=%b exp=%b", irq_clr, e.clr); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL level_no_repend_req got=%b exp=0", int_req); end
    io_read(8'h01, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL level_no_repend got=%h exp=00", rd); end
    irq_in = 4'b0000;
    tick();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    checks++; if (irq_clr !== 4'b0000) begin errors++; $display("FAIL stray_ack_clr got=%b exp=0000", irq_clr); end
  endtask

  task automatic test_priority_mode();
`ifdef IRQ_ROTATE_PRIORITY_EN
    exp_q.push_back('{vec: 16'h0008, clr: 4'b0001});
    exp_q.push_back('{vec: 16'h000C, clr: 4'b0010});
    exp_q.push_back('{vec: 16'h0008, clr: 4'b0001});
`else
    exp_q.push_back('{vec: 16'h0008, clr: 4'b0001});
    exp_q.push_back('{vec: 16'h0008, clr: 4'b0001});
    exp_q.push_back('{vec: 16'h000C, clr: 4'b0010});
`endif
    irq_in = 4'b0011;
    tick();
    irq_in = 4'b0000;
    for (int n = 0; n < 3; n++) begin
      wait_req(10, seen);
      checks++; if (!seen) begin errors++; $display("FAIL prio_req_timeout grant=%0d got=0 exp=1", n); end
      e = exp_q.pop_front();
      checks++; if (int_vector !== e.vec) begin errors++; $display("FAIL prio_vector grant=%0d got=%h exp=%h", n, int_vector, e.vec); end
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      checks++; if (irq_clr !== e.clr) begin errors++; $display("FAIL prio_clr grant=%0d got=%b exp=%b", n, irq_clr, e.clr); end
      if (n == 0) begin
        irq_in = 4'b0001;
        tick();
        irq_in = 4'b0000;
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_req();
    irq_in = 4'b0100;
    tick();
    irq_in = 4'b0000;
    wait_req(10, seen);
    checks++; if (!seen) begin errors++; $display("FAIL midreset_req_timeout got=0 exp=1"); end
    reset   = 1'b1;
    int_ack = 1'b1;
    tick();
    reset   = 1'b0;
    int_ack = 1'b0;
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL midreset_req got=%b exp=0", int_req); end
    checks++; if (irq_clr !== 4'b0000) begin errors++; $display("FAIL midreset_clr got=%b exp=0000", irq_clr); end
    tick();
    checks++; if (irq_clr !== 4'b0000) begin errors++; $display("FAIL midreset_clr_late got=%b exp=0000", irq_clr); end
    io_read(8'h01, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL midreset_pending got=%h exp=00", rd); end
  endtask

  initial begin
    reset    = 1'b1;
    irq_in   = 4'b0000;
    cpu_ie   = 1'b0;
    int_ack  = 1'b0;
    io_addr  = 8'h00;
    io_wr_en = 1'b0;
    io_rd_en = 1'b0;
    io_din   = 8'h00;
    test_reset();
    test_retire();
    test_simultaneous();
    test_masking();
    test_withdraw();
    test_w1c_race();
    test_level_hold();
    test_priority_mode();
    test_reset_mid_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
